// File: rtl/sync_bus_pkg.sv
// Shared definitions for the timing-bus generator: bus bit positions and
// the sequencer state encoding.
package sync_bus_pkg;

  localparam int BUS_W    = 8;

  localparam int BIT_CLK5 = 0;
  localparam int BIT_RSV  = 1;
  localparam int BIT_TNC  = 2;
  localparam int BIT_TNO  = 3;
  localparam int BIT_TNP  = 4;
  localparam int BIT_TKP  = 5;
  localparam int BIT_TNI  = 6;
  localparam int BIT_TKI  = 7;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_e;

endpackage

// File: rtl/sync_bus_gen_tick_div.sv
// Free-running divider: produces the 5 MHz reference square wave and a
// one-clock tick flag on the last count of each 5 MHz period. The square
// wave is registered from the next count value, so it rises on the same
// edge that consumes the tick.
module tick_div #(
  parameter int DIV = 20,
  parameter int PW  = 16
) (
  input  logic clk,
  input  logic rst,
  output logic clk5_o,
  output logic tick_o
);

  localparam logic [PW-1:0] LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] HALF = PW'(DIV / 2);

  logic [PW-1:0] div_cnt_q, div_cnt_d;
  logic          clk5_q;

  // Next divider count, wrapping at DIV-1.
  always_comb begin
    div_cnt_d = (div_cnt_q == LAST) ? '0 : div_cnt_q + PW'(1);
  end

  // Divider register and registered square wave (high for the first half).
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      clk5_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      clk5_q    <= (div_cnt_d < HALF);
    end
  end

  assign clk5_o = clk5_q;
  assign tick_o = (div_cnt_q == LAST);

endmodule

// File: rtl/sync_bus_gen.sv
// Timing-bus generator: 5 MHz reference plus the TNC/TNO/TNP/TKP/TNI/TKI
// strobe sequence. Counters always describe the slot currently on the bus;
// on each tick the next slot is computed and its strobes registered.
module sync_bus_gen
  import sync_bus_pkg::*;
#(
  parameter int DIV = 20,
  parameter int PW  = 16,
  parameter int CW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [PW-1:0]    cfg_period_len,
  input  logic [PW-1:0]    cfg_int_start,
  input  logic [PW-1:0]    cfg_int_stop,
  input  logic [CW-1:0]    cfg_cycle_periods,
  input  logic [CW-1:0]    cfg_obs_cycles,
  output logic [BUS_W-1:0] bus_clk,
  output logic             running,
  output logic [CW-1:0]    period_idx
);

  logic clk5;
  logic tick;

  tick_div #(.DIV(DIV), .PW(PW)) u_tick_div (
    .clk    (clk),
    .rst    (rst),
    .clk5_o (clk5),
    .tick_o (tick)
  );

  seq_state_e state_q, state_d;

  logic [PW-1:0] tick_cnt_q, tick_cnt_d;
  logic [CW-1:0] period_cnt_q, period_cnt_d;
  logic [CW-1:0] cycle_cnt_q, cycle_cnt_d;

  // Config shadows, already clamped to legal values.
  logic [PW-1:0] plen_q, plen_d;
  logic [PW-1:0] istart_q, istart_d;
  logic [PW-1:0] istop_q, istop_d;
  logic [CW-1:0] cper_q, cper_d;
  logic [CW-1:0] obs_q, obs_d;

  logic [BIT_TKI:BIT_TNC] strobe_q, strobe_d;
  logic                   running_q, running_d;

  logic [PW-1:0] eff_plen;
  logic [CW-1:0] eff_cper;
  logic [CW-1:0] eff_obs;
  logic          tkp_now;
  logic          issue;

  // Illegal geometry is clamped before it reaches the shadows.
  assign eff_plen = (cfg_period_len < PW'(2)) ? PW'(2) : cfg_period_len;
  assign eff_cper = (cfg_cycle_periods == '0) ? CW'(1) : cfg_cycle_periods;
  assign eff_obs  = (cfg_obs_cycles == '0)    ? CW'(1) : cfg_obs_cycles;

  // The slot currently on the bus is the last of its period.
  assign tkp_now = (tick_cnt_q == plen_q - PW'(1));

  // Sequencer next state, counter advance, shadow reload and strobe decode.
  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    period_cnt_d = period_cnt_q;
    cycle_cnt_d  = cycle_cnt_q;
    plen_d       = plen_q;
    istart_d     = istart_q;
    istop_d      = istop_q;
    cper_d       = cper_q;
    obs_d        = obs_q;
    strobe_d     = strobe_q;
    running_d    = running_q;
    issue        = 1'b0;

    if (tick) begin
      case (state_q)
        IDLE: begin
          strobe_d  = '0;
          running_d = 1'b0;
          if (en) begin
            state_d      = RUN;
            tick_cnt_d   = '0;
            period_cnt_d = '0;
            cycle_cnt_d  = '0;
            plen_d       = eff_plen;
            istart_d     = cfg_int_start;
            istop_d      = cfg_int_stop;
            cper_d       = eff_cper;
            obs_d        = eff_obs;
            issue        = 1'b1;
          end
        end
        RUN: begin
          if (!en && tkp_now) begin
            // Period just completed and run request gone: go quiet.
            state_d      = IDLE;
            tick_cnt_d   = '0;
            period_cnt_d = '0;
            cycle_cnt_d  = '0;
            strobe_d     = '0;
            running_d    = 1'b0;
          end else begin
            if (tick_cnt_q >= plen_q - PW'(1)) begin
              tick_cnt_d = '0;
              if (period_cnt_q >= cper_q - CW'(1)) begin
                // Cycle boundary: the next slot carries TNC, so the new
                // geometry is picked up here and used for that slot.
                period_cnt_d = '0;
                cycle_cnt_d  = (cycle_cnt_q >= obs_q - CW'(1)) ? '0
                                                               : cycle_cnt_q + CW'(1);
                plen_d       = eff_plen;
                istart_d     = cfg_int_start;
                istop_d      = cfg_int_stop;
                cper_d       = eff_cper;
                obs_d        = eff_obs;
              end else begin
                period_cnt_d = period_cnt_q + CW'(1);
              end
            end else begin
              tick_cnt_d = tick_cnt_q + PW'(1);
            end
            issue = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    if (issue) begin
      strobe_d          = '0;
      strobe_d[BIT_TNP] = (tick_cnt_d == '0);
      strobe_d[BIT_TKP] = (tick_cnt_d == plen_d - PW'(1));
      strobe_d[BIT_TNC] = (tick_cnt_d == '0) && (period_cnt_d == '0);
      strobe_d[BIT_TNO] = (tick_cnt_d == '0) && (period_cnt_d == '0) && (cycle_cnt_d == '0);
      strobe_d[BIT_TNI] = (tick_cnt_d == istart_d) && (istart_d < plen_d);
      strobe_d[BIT_TKI] = (tick_cnt_d == istop_d) && (istop_d < plen_d);
      running_d         = 1'b1;
    end
  end

  // State, counters, shadows and registered strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      tick_cnt_q   <= '0;
      period_cnt_q <= '0;
      cycle_cnt_q  <= '0;
      plen_q       <= '0;
      istart_q     <= '0;
      istop_q      <= '0;
      cper_q       <= '0;
      obs_q        <= '0;
      strobe_q     <= '0;
      running_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      period_cnt_q <= period_cnt_d;
      cycle_cnt_q  <= cycle_cnt_d;
      plen_q       <= plen_d;
      istart_q     <= istart_d;
      istop_q      <= istop_d;
      cper_q       <= cper_d;
      obs_q        <= obs_d;
      strobe_q     <= strobe_d;
      running_q    <= running_d;
    end
  end

  // Bus assembly: reserved bit tied low.
  always_comb begin
    bus_clk                  = '0;
    bus_clk[BIT_TKI:BIT_TNC] = strobe_q;
    bus_clk[BIT_RSV]         = 1'b0;
    bus_clk[BIT_CLK5]        = clk5;
  end

  assign running    = running_q;
  assign period_idx = period_cnt_q;

endmodule

// File: tb/tb_sync_bus_gen.sv
// Bench for sync_bus_gen: directed scenarios plus randomized config/enable
// segments, every clock compared against a slot-position reference model.
module tb_sync_bus_gen;

  localparam int DIV = 20;
  localparam int PW  = 16;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [PW-1:0] cfg_period_len, cfg_int_start, cfg_int_stop;
  logic [CW-1:0] cfg_cycle_periods, cfg_obs_cycles;
  logic [7:0]    bus_clk;
  logic          running;
  logic [CW-1:0] period_idx;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sync_bus_gen #(.DIV(DIV), .PW(PW), .CW(CW)) dut (
    .clk               (clk),
    .rst               (rst),
    .en                (en),
    .cfg_period_len    (cfg_period_len),
    .cfg_int_start     (cfg_int_start),
    .cfg_int_stop      (cfg_int_stop),
    .cfg_cycle_periods (cfg_cycle_periods),
    .cfg_obs_cycles    (cfg_obs_cycles),
    .bus_clk           (bus_clk),
    .running           (running),
    .period_idx        (period_idx)
  );

  // Reference model: position within the current cycle plus cycle index.
  int       m_div, m_pos, m_cyc;
  int       sp_len, sp_cp, sp_obs, sp_is, sp_ie;
  bit       m_run, m_clk5, m_running;
  int       m_pidx;
  bit [5:0] m_strb; // {TKI,TNI,TKP,TNP,TNO,TNC}

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic snapshot();
    sp_len = (cfg_period_len < 2) ? 2 : int'(cfg_period_len);
    sp_cp  = (cfg_cycle_periods == 0) ? 1 : int'(cfg_cycle_periods);
    sp_obs = (cfg_obs_cycles == 0) ? 1 : int'(cfg_obs_cycles);
    sp_is  = int'(cfg_int_start);
    sp_ie  = int'(cfg_int_stop);
  endtask

  task automatic emit();
    int t;
    t = m_pos % sp_len;
    m_strb[0] = (m_pos == 0);
    m_strb[1] = (m_pos == 0) && (m_cyc == 0);
    m_strb[2] = (t == 0);
    m_strb[3] = (t == sp_len - 1);
    m_strb[4] = (t == sp_is);
    m_strb[5] = (t == sp_ie);
    m_pidx    = m_pos / sp_len;
    m_running = 1'b1;
  endtask

  task automatic model_edge();
    bit tick;
    if (rst) begin
      m_div = 0; m_clk5 = 0; m_run = 0; m_strb = '0;
      m_running = 0; m_pidx = 0; m_pos = 0; m_cyc = 0;
      return;
    end
    tick   = (m_div == DIV - 1);
    m_div  = (m_div + 1) % DIV;
    m_clk5 = (m_div < DIV / 2);
    if (!tick) return;
    if (!m_run) begin
      if (en) begin
        snapshot();
        m_pos = 0; m_cyc = 0; m_run = 1;
        emit();
      end
    end else if (!en && (m_pos % sp_len == sp_len - 1)) begin
      m_run = 0; m_strb = '0; m_running = 0; m_pidx = 0;
    end else begin
      m_pos++;
      if (m_pos == sp_len * sp_cp) begin
        m_pos = 0;
        m_cyc = (m_cyc + 1 >= sp_obs) ? 0 : m_cyc + 1;
        snapshot();
      end
      emit();
    end
  endtask

  // One clock: model follows the edge, outputs compared half a clock later.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("bus", {24'd0, bus_clk}, {24'd0, m_strb, 1'b0, m_clk5});
    chk("running", {31'd0, running}, {31'd0, m_running});
    chk("period_idx", {24'd0, period_idx}, m_pidx);
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_cfg(input int pl, input int is, input int ie, input int cp, input int ob);
    cfg_period_len    = PW'(pl);
    cfg_int_start     = PW'(is);
    cfg_int_stop      = PW'(ie);
    cfg_cycle_periods = CW'(cp);
    cfg_obs_cycles    = CW'(ob);
  endtask

  task automatic wait_running();
    int n;
    n = 0;
    while (running !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("running_rise", {31'd0, running}, 32'd1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    run_n(2);
    rst = 1'b0;
  endtask

  logic [7:0] pat [5];

  initial begin
    pat[0] = 8'h1D; pat[1] = 8'h41; pat[2] = 8'h01; pat[3] = 8'h81; pat[4] = 8'h21;
    rst = 1'b1;
    en  = 1'b0;
    set_cfg(0, 0, 0, 0, 0);
    run_n(3);
    chk("reset_bus", {24'd0, bus_clk}, 32'd0);
    rst = 1'b0;
    run_n(60);
    $display("reset/idle divider: %0d compared", n_cmp);

    // First period strobe order.
    set_cfg(5, 1, 3, 2, 2);
    en = 1'b1;
    wait_running();
    for (int k = 0; k < 5; k++) begin
      run_n(5);
      chk($sformatf("slot%0d", k), {24'd0, bus_clk}, {24'd0, pat[k]});
      run_n(15);
    end
    run_n(700);
    $display("period/hierarchy run: %0d compared", n_cmp);

    // Config change mid-cycle, then stop.
    run_n(130);
    cfg_period_len = PW'(3);
    run_n(800);
    en = 1'b0;
    run_n(250);
    chk("stopped", {31'd0, running}, 32'd0);
    $display("config change and stop: %0d compared", n_cmp);

    // Interrupt index outside the period.
    pulse_reset();
    set_cfg(5, 7, 2, 1, 1);
    en = 1'b1;
    run_n(600);
    $display("int_start out of range: %0d compared", n_cmp);

    // Coincident TNI/TKI on tick 0.
    pulse_reset();
    set_cfg(5, 0, 0, 1, 1);
    wait_running();
    run_n(5);
    chk("same_slot", {24'd0, bus_clk}, 32'h0000_00DD);
    run_n(150);

    // Reset in the middle of RUN.
    rst = 1'b1;
    step();
    chk("rst_bus", {24'd0, bus_clk}, 32'd0);
    chk("rst_running", {31'd0, running}, 32'd0);
    rst = 1'b0;
    run_n(40);
    $display("boundaries and mid-run reset: %0d compared", n_cmp);

    // Randomized segments.
    for (int s = 0; s < 30; s++) begin
      int len;
      if ($urandom_range(0, 3) != 0)
        set_cfg($urandom_range(0, 6), $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 3), $urandom_range(0, 3));
      else
        cfg_period_len = PW'($urandom_range(0, 6));
      en  = ($urandom_range(0, 3) != 0);
      len = $urandom_range(40, 400);
      if ($urandom_range(0, 9) == 0) pulse_reset();
      run_n(len);
      $display("segment %0d: plen=%0d is=%0d ie=%0d cp=%0d obs=%0d en=%0b clocks=%0d errors=%0d",
               s, cfg_period_len, cfg_int_start, cfg_int_stop, cfg_cycle_periods,
               cfg_obs_cycles, en, len, n_err);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
